// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order FIFO of predicted branches between fetch and
// execute. Pops on resolve, drives the BHT update port and a fetch redirect
// on mispredict, and flushes all younger (wrong-path) entries when the
// prediction was wrong.
// Optional feature macro: BRQ_STATS_EN adds saturating resolve/mispredict
// counters on ports o_stat_resolved / o_stat_mispred.
module branch_resolve_queue #(
    parameter int PC_W   = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_push,
    input  logic [PC_W-1:0]   i_push_pc,
    input  logic              i_push_pred,
    input  logic [PC_W-1:0]   i_push_target,
    input  logic [PC_W-1:0]   i_push_fall,
    input  logic              i_resolve_valid,
    input  logic              i_resolve_taken,
    output logic              o_upd_branch,
    output logic [PC_W-1:0]   o_upd_pc,
    output logic              o_upd_taken,
    output logic              o_mispredict,
    output logic [PC_W-1:0]   o_redirect_pc,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W:0]   o_count,
    output logic              o_underflow
`ifdef BRQ_STATS_EN
    ,
    output logic [15:0]       o_stat_resolved,
    output logic [15:0]       o_stat_mispred
`endif
);

    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ZERO = (ADDR_W+1)'(0);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);

    logic [PC_W-1:0]   r_pc_mem   [DEPTH];
    logic              r_pred_mem [DEPTH];
    logic [PC_W-1:0]   r_tgt_mem  [DEPTH];
    logic [PC_W-1:0]   r_fall_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;

    logic [PC_W-1:0]   w_head_pc;
    logic              w_head_pred;
    logic [PC_W-1:0]   w_head_tgt;
    logic [PC_W-1:0]   w_head_fall;
    logic              w_pop;
    logic              w_mis;
    logic              w_push_ok;
    logic [ADDR_W:0]   w_count_nxt;

    // Head read, pop/flush decisions and next occupancy.
    always_comb begin
        w_head_pc   = r_pc_mem[r_rd_ptr];
        w_head_pred = r_pred_mem[r_rd_ptr];
        w_head_tgt  = r_tgt_mem[r_rd_ptr];
        w_head_fall = r_fall_mem[r_rd_ptr];
        w_pop       = i_resolve_valid && (r_count != CNT_ZERO);
        w_mis       = w_pop && (i_resolve_taken != w_head_pred);
        // A push during a flush is wrong-path; a push when full needs a pop to make room.
        w_push_ok   = i_push && !w_mis && ((r_count != CNT_FULL) || w_pop);
        w_count_nxt = r_count;
        if (w_mis) begin
            w_count_nxt = CNT_ZERO;
        end else begin
            case ({w_push_ok, w_pop})
                2'b10:   w_count_nxt = r_count + CNT_ONE;
                2'b01:   w_count_nxt = r_count - CNT_ONE;
                default: w_count_nxt = r_count;
            endcase
        end
    end

    // Entry storage: write the new branch at the tail.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pc_mem[i]   <= '0;
                r_pred_mem[i] <= 1'b0;
                r_tgt_mem[i]  <= '0;
                r_fall_mem[i] <= '0;
            end
        end else if (w_push_ok) begin
            r_pc_mem[r_wr_ptr]   <= i_push_pc;
            r_pred_mem[r_wr_ptr] <= i_push_pred;
            r_tgt_mem[r_wr_ptr]  <= i_push_target;
            r_fall_mem[r_wr_ptr] <= i_push_fall;
        end
    end

    // Pointers, occupancy and registered status flags.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= CNT_ZERO;
            o_count     <= CNT_ZERO;
            o_full      <= 1'b0;
            o_empty     <= 1'b1;
            o_underflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            // A flush drops everything younger than the resolved head.
            if (w_mis) begin
                r_rd_ptr <= r_wr_ptr;
            end else if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_count <= w_count_nxt;
            o_count <= w_count_nxt;
            o_full  <= (w_count_nxt == CNT_FULL);
            o_empty <= (w_count_nxt == CNT_ZERO);
            if (i_resolve_valid && (r_count == CNT_ZERO)) begin
                o_underflow <= 1'b1;
            end
        end
    end

    // BHT update and redirect outputs, one cycle after the pop.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_upd_branch  <= 1'b0;
            o_upd_pc      <= '0;
            o_upd_taken   <= 1'b0;
            o_mispredict  <= 1'b0;
            o_redirect_pc <= '0;
        end else begin
            o_upd_branch <= w_pop;
            o_mispredict <= w_mis;
            if (w_pop) begin
                o_upd_pc      <= w_head_pc;
                o_upd_taken   <= i_resolve_taken;
                o_redirect_pc <= i_resolve_taken ? w_head_tgt : w_head_fall;
            end
        end
    end

`ifdef BRQ_STATS_EN
    // Saturating counters of resolved and mispredicted branches.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_stat_resolved <= 16'h0000;
            o_stat_mispred  <= 16'h0000;
        end else begin
            if (w_pop && (o_stat_resolved != 16'hFFFF)) begin
                o_stat_resolved <= o_stat_resolved + 16'h0001;
            end
            if (w_mis && (o_stat_mispred != 16'hFFFF)) begin
                o_stat_mispred <= o_stat_mispred + 16'h0001;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Self-checking bench for branch_resolve_queue: table-driven vectors for the
// main queue behaviour plus hand-written reset and statistics sequences.
module tb_branch_resolve_queue;

    logic       clk = 1'b0;
    logic       reset, push, push_pred, resolve_valid, resolve_taken;
    logic [7:0] push_pc, push_target, push_fall;
    logic       upd_branch, upd_taken, mispredict, full, empty, underflow;
    logic [7:0] upd_pc, redirect_pc;
    logic [2:0] count;
`ifdef BRQ_STATS_EN
    logic [15:0] stat_resolved, stat_mispred;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    branch_resolve_queue #(.PC_W(8), .DEPTH(4), .ADDR_W(2)) dut (
        .i_clk(clk), .i_reset(reset), .i_push(push), .i_push_pc(push_pc),
        .i_push_pred(push_pred), .i_push_target(push_target), .i_push_fall(push_fall),
        .i_resolve_valid(resolve_valid), .i_resolve_taken(resolve_taken),
        .o_upd_branch(upd_branch), .o_upd_pc(upd_pc), .o_upd_taken(upd_taken),
        .o_mispredict(mispredict), .o_redirect_pc(redirect_pc), .o_full(full),
        .o_empty(empty), .o_count(count), .o_underflow(underflow)
`ifdef BRQ_STATS_EN
        , .o_stat_resolved(stat_resolved), .o_stat_mispred(stat_mispred)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       push;
        logic [7:0] pc;
        logic       pred;
        logic [7:0] tgt;
        logic [7:0] fall;
        logic       rv;
        logic       rt;
        logic       e_ub;
        logic [7:0] e_pc;
        logic       e_t;
        logic       e_mis;
        logic [7:0] e_red;
        logic       e_full;
        logic       e_empty;
        logic [2:0] e_cnt;
        logic       e_uf;
    } vec_t;

    localparam int NV = 20;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic p, input logic [7:0] pc, input logic pr,
                                input logic [7:0] tg, input logic [7:0] fa,
                                input logic rv, input logic rt,
                                input logic ub, input logic [7:0] epc, input logic et,
                                input logic mis, input logic [7:0] red, input logic fu,
                                input logic em, input logic [2:0] cn, input logic uf);
        vec_t v;
        v.push = p; v.pc = pc; v.pred = pr; v.tgt = tg; v.fall = fa; v.rv = rv; v.rt = rt;
        v.e_ub = ub; v.e_pc = epc; v.e_t = et; v.e_mis = mis; v.e_red = red;
        v.e_full = fu; v.e_empty = em; v.e_cnt = cn; v.e_uf = uf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic p, input logic [7:0] pc, input logic pr,
                         input logic [7:0] tg, input logic [7:0] fa,
                         input logic rv, input logic rt);
        push = p; push_pc = pc; push_pred = pr; push_target = tg; push_fall = fa;
        resolve_valid = rv; resolve_taken = rt;
    endtask

    // Apply inputs at the falling edge, let one rising edge pass, sample at the next falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        //                p    pc    pr  tgt    fall   rv   rt   ub   pc     t    mis  red    full em   cnt   uf
        // Test 1: correct taken resolve
        tbl[0]  = mk(1'b1, 8'h10, 1'b1, 8'h40, 8'h11, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd1, 1'b0);
        tbl[1]  = mk(1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 8'h10, 1'b1, 1'b0, 8'h40, 1'b0, 1'b1, 3'd0, 1'b0);
        // Test 2: mispredict flush, push in flush cycle dropped
        tbl[2]  = mk(1'b1, 8'h20, 1'b0, 8'h50, 8'h21, 1'b0, 1'b0, 1'b0, 8'h10, 1'b1, 1'b0, 8'h40, 1'b0, 1'b0, 3'd1, 1'b0);
        tbl[3]  = mk(1'b1, 8'h21, 1'b0, 8'h51, 8'h22, 1'b0, 1'b0, 1'b0, 8'h10, 1'b1, 1'b0, 8'h40, 1'b0, 1'b0, 3'd2, 1'b0);
        tbl[4]  = mk(1'b1, 8'h22, 1'b0, 8'h52, 8'h23, 1'b0, 1'b0, 1'b0, 8'h10, 1'b1, 1'b0, 8'h40, 1'b0, 1'b0, 3'd3, 1'b0);
        tbl[5]  = mk(1'b1, 8'h30, 1'b0, 8'h60, 8'h31, 1'b1, 1'b1, 1'b1, 8'h20, 1'b1, 1'b1, 8'h50, 1'b0, 1'b1, 3'd0, 1'b0);
        tbl[6]  = mk(1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h20, 1'b1, 1'b0, 8'h50, 1'b0, 1'b1, 3'd0, 1'b0);
        // Test 3: fill, overflow push ignored, push+pop at full, order preserved
        tbl[7]  = mk(1'b1, 8'h80, 1'b1, 8'h90, 8'h81, 1'b0, 1'b0, 1'b0, 8'h20, 1'b1, 1'b0, 8'h50, 1'b0, 1'b0, 3'd1, 1'b0);
        tbl[8]  = mk(1'b1, 8'h82, 1'b0, 8'h92, 8'h83, 1'b0, 1'b0, 1'b0, 8'h20, 1'b1, 1'b0, 8'h50, 1'b0, 1'b0, 3'd2, 1'b0);
        tbl[9]  = mk(1'b1, 8'h84, 1'b1, 8'h94, 8'h85, 1'b0, 1'b0, 1'b0, 8'h20, 1'b1, 1'b0, 8'h50, 1'b0, 1'b0, 3'd3, 1'b0);
        tbl[10] = mk(1'b1, 8'h86, 1'b0, 8'h96, 8'h87, 1'b0, 1'b0, 1'b0, 8'h20, 1'b1, 1'b0, 8'h50, 1'b1, 1'b0, 3'd4, 1'b0);
        tbl[11] = mk(1'b1, 8'h88, 1'b1, 8'h98, 8'h89, 1'b0, 1'b0, 1'b0, 8'h20, 1'b1, 1'b0, 8'h50, 1'b1, 1'b0, 3'd4, 1'b0);
        tbl[12] = mk(1'b1, 8'h8A, 1'b0, 8'hA0, 8'h8B, 1'b1, 1'b1, 1'b1, 8'h80, 1'b1, 1'b0, 8'h90, 1'b1, 1'b0, 3'd4, 1'b0);
        tbl[13] = mk(1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'h82, 1'b0, 1'b0, 8'h83, 1'b0, 1'b0, 3'd3, 1'b0);
        tbl[14] = mk(1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 8'h84, 1'b1, 1'b0, 8'h94, 1'b0, 1'b0, 3'd2, 1'b0);
        tbl[15] = mk(1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'h86, 1'b0, 1'b0, 8'h87, 1'b0, 1'b0, 3'd1, 1'b0);
        tbl[16] = mk(1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'h8A, 1'b0, 1'b0, 8'h8B, 1'b0, 1'b1, 3'd0, 1'b0);
        // Test 4: resolve while empty (no bypass of same-cycle push), sticky underflow
        tbl[17] = mk(1'b1, 8'hC0, 1'b1, 8'hD0, 8'hC1, 1'b1, 1'b1, 1'b0, 8'h8A, 1'b0, 1'b0, 8'h8B, 1'b0, 1'b0, 3'd1, 1'b1);
        tbl[18] = mk(1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'hC0, 1'b0, 1'b1, 8'hC1, 1'b0, 1'b1, 3'd0, 1'b1);
        tbl[19] = mk(1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'hC0, 1'b0, 1'b0, 8'hC1, 1'b0, 1'b1, 3'd0, 1'b1);

        reset = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        step();
        reset = 1'b0;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_upd_branch", 32'(upd_branch), 32'd0);
        chk("rst_mispredict", 32'(mispredict), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].push, tbl[i].pc, tbl[i].pred, tbl[i].tgt, tbl[i].fall, tbl[i].rv, tbl[i].rt);
            step();
            chk($sformatf("v%0d_upd_branch", i), 32'(upd_branch), 32'(tbl[i].e_ub));
            chk($sformatf("v%0d_upd_pc", i), 32'(upd_pc), 32'(tbl[i].e_pc));
            chk($sformatf("v%0d_upd_taken", i), 32'(upd_taken), 32'(tbl[i].e_t));
            chk($sformatf("v%0d_mispredict", i), 32'(mispredict), 32'(tbl[i].e_mis));
            chk($sformatf("v%0d_redirect_pc", i), 32'(redirect_pc), 32'(tbl[i].e_red));
            chk($sformatf("v%0d_full", i), 32'(full), 32'(tbl[i].e_full));
            chk($sformatf("v%0d_empty", i), 32'(empty), 32'(tbl[i].e_empty));
            chk($sformatf("v%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
            chk($sformatf("v%0d_underflow", i), 32'(underflow), 32'(tbl[i].e_uf));
        end

        // Test 5: reset with 3 entries queued and a resolve pending
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'(8'h60 + i), 1'b1, 8'h70, 8'h61, 1'b0, 1'b0);
            step();
        end
        chk("pre_rst_count", 32'(count), 32'd3);
        reset = 1'b1;
        drive(1'b1, 8'h66, 1'b0, 8'h77, 8'h67, 1'b1, 1'b0);
        step();
        reset = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        chk("rst2_count", 32'(count), 32'd0);
        chk("rst2_empty", 32'(empty), 32'd1);
        chk("rst2_upd_branch", 32'(upd_branch), 32'd0);
        chk("rst2_mispredict", 32'(mispredict), 32'd0);
        chk("rst2_upd_pc", 32'(upd_pc), 32'd0);
        chk("rst2_redirect_pc", 32'(redirect_pc), 32'd0);
        chk("rst2_underflow", 32'(underflow), 32'd0);
        // Queue works normally after reset: pointers back at 0
        drive(1'b1, 8'h33, 1'b0, 8'h44, 8'h34, 1'b0, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        chk("post_rst_upd_pc", 32'(upd_pc), 32'h33);
        chk("post_rst_redirect", 32'(redirect_pc), 32'h34);
        chk("post_rst_upd_branch", 32'(upd_branch), 32'd1);
        chk("post_rst_empty", 32'(empty), 32'd1);

`ifdef BRQ_STATS_EN
        // Test 6: 5 pops, 2 mispredicting (pairs of push then resolve)
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("stat_rst_resolved", 32'(stat_resolved), 32'd0);
        chk("stat_rst_mispred", 32'(stat_mispred), 32'd0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'(i), 1'b1, 8'h10, 8'h11, 1'b0, 1'b0);
            step();
            drive(1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, (i < 2) ? 1'b0 : 1'b1);
            step();
        end
        drive(1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        chk("stat_resolved_5", 32'(stat_resolved), 32'd5);
        chk("stat_mispred_2", 32'(stat_mispred), 32'd2);
        // Drive the resolve counter to saturation with back-to-back push + correct pop
        drive(1'b1, 8'h01, 1'b1, 8'h10, 8'h11, 1'b0, 1'b0);
        step();
        drive(1'b1, 8'h01, 1'b1, 8'h10, 8'h11, 1'b1, 1'b1);
        for (int i = 0; i < 65540; i++) begin
            @(posedge clk);
        end
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        chk("stat_resolved_sat", 32'(stat_resolved), 32'hFFFF);
        chk("stat_mispred_hold", 32'(stat_mispred), 32'd2);
        chk("stat_count_one", 32'(count), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
